// File: rtl/zbuf_pkg.sv
// Shared types for the z-buffer rasteriser: point layout, line walker states
// and the signed Bresenham error type.
package zbuf_pkg;

  localparam int COORD_W = 8;
  localparam int POINT_W = 3 * COORD_W;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } point_t;

  typedef enum logic [1:0] {IDLE, SETUP, RUN} line_state_t;

  typedef enum logic [1:0] {AXIS_X, AXIS_Y, AXIS_Z} axis_t;

  typedef logic signed [COORD_W+2:0] err_t;

  function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                     input logic              neg);
    return neg ? c - COORD_W'(1) : c + COORD_W'(1);
  endfunction

  // 2*v widened into the error domain; never overflows since v < 2**COORD_W.
  function automatic err_t twice(input logic [COORD_W-1:0] v);
    return err_t'({2'b00, v, 1'b0});
  endfunction

endpackage

// File: rtl/line_setup.sv
// Combinational line setup: per-axis deltas and directions, major-axis choice
// (ties resolved x > y > z) and the initial minor-axis errors.
module line_setup
  import zbuf_pkg::*;
(
  input  point_t             p1,
  input  point_t             p2,
  output axis_t              major,
  output axis_t              minor1,
  output axis_t              minor2,
  output logic [2:0]         neg,
  output logic [COORD_W-1:0] d,
  output logic [COORD_W-1:0] a1,
  output logic [COORD_W-1:0] a2,
  output err_t               e1,
  output err_t               e2
);

  logic [COORD_W-1:0] ax;
  logic [COORD_W-1:0] ay;
  logic [COORD_W-1:0] az;

  always_comb begin
    neg    = {p2.x < p1.x, p2.y < p1.y, p2.z < p1.z};
    ax     = neg[2] ? p1.x - p2.x : p2.x - p1.x;
    ay     = neg[1] ? p1.y - p2.y : p2.y - p1.y;
    az     = neg[0] ? p1.z - p2.z : p2.z - p1.z;
    major  = AXIS_X;
    minor1 = AXIS_Y;
    minor2 = AXIS_Z;
    d      = ax;
    a1     = ay;
    a2     = az;
    if (ax >= ay && ax >= az) begin
      major  = AXIS_X;
      minor1 = AXIS_Y;
      minor2 = AXIS_Z;
      d      = ax;
      a1     = ay;
      a2     = az;
    end else if (ay >= az) begin
      major  = AXIS_Y;
      minor1 = AXIS_X;
      minor2 = AXIS_Z;
      d      = ay;
      a1     = ax;
      a2     = az;
    end else begin
      major  = AXIS_Z;
      minor1 = AXIS_X;
      minor2 = AXIS_Y;
      d      = az;
      a1     = ax;
      a2     = ay;
    end
    e1 = twice(a1) - err_t'({3'b000, d});
    e2 = twice(a2) - err_t'({3'b000, d});
  end

endmodule

// File: rtl/bresenham_line.sv
// 3D Bresenham line walker: latches an edge on request, then emits one point
// per accepted step from point_1 to point_2 inclusive, flagging the last with eoc.
module bresenham_line
  import zbuf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_line,
  output logic               ack_line,
  input  logic [POINT_W-1:0] point_1,
  input  logic [POINT_W-1:0] point_2,
  input  logic               step,
  output logic [POINT_W-1:0] point_out,
  output logic               point_valid,
  output logic               eoc,
  output logic               busy
);

  localparam int ERR_MSB = COORD_W + 2;

  line_state_t        state_q;
  line_state_t        state_d;
  logic               accept;
  logic               advance;

  point_t             p1_q;
  point_t             p2_q;
  point_t             pos_q;
  point_t             pos_nxt;
  logic [2:0]         neg_q;
  axis_t              maj_q;
  axis_t              min1_q;
  axis_t              min2_q;
  logic [COORD_W-1:0] d_q;
  logic [COORD_W-1:0] a1_q;
  logic [COORD_W-1:0] a2_q;
  logic [COORD_W-1:0] cnt_q;
  err_t               e1_q;
  err_t               e2_q;
  err_t               e1_nxt;
  err_t               e2_nxt;
  logic               vld_q;
  logic               ack_q;
  logic               busy_q;

  axis_t              su_major;
  axis_t              su_minor1;
  axis_t              su_minor2;
  logic [2:0]         su_neg;
  logic [COORD_W-1:0] su_d;
  logic [COORD_W-1:0] su_a1;
  logic [COORD_W-1:0] su_a2;
  err_t               su_e1;
  err_t               su_e2;

  logic               mv_x;
  logic               mv_y;
  logic               mv_z;

  line_setup u_setup (
    .p1     (p1_q),
    .p2     (p2_q),
    .major  (su_major),
    .minor1 (su_minor1),
    .minor2 (su_minor2),
    .neg    (su_neg),
    .d      (su_d),
    .a1     (su_a1),
    .a2     (su_a2),
    .e1     (su_e1),
    .e2     (su_e2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_line) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = RUN;
      RUN: begin
        advance = vld_q && step;
        if (advance && cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One step: the major axis always moves, a minor axis moves when its error is non-negative.
  always_comb begin
    mv_x = (maj_q == AXIS_X) || (min1_q == AXIS_X && !e1_q[ERR_MSB])
                             || (min2_q == AXIS_X && !e2_q[ERR_MSB]);
    mv_y = (maj_q == AXIS_Y) || (min1_q == AXIS_Y && !e1_q[ERR_MSB])
                             || (min2_q == AXIS_Y && !e2_q[ERR_MSB]);
    mv_z = (maj_q == AXIS_Z) || (min1_q == AXIS_Z && !e1_q[ERR_MSB])
                             || (min2_q == AXIS_Z && !e2_q[ERR_MSB]);
    pos_nxt.x = mv_x ? step_coord(pos_q.x, neg_q[2]) : pos_q.x;
    pos_nxt.y = mv_y ? step_coord(pos_q.y, neg_q[1]) : pos_q.y;
    pos_nxt.z = mv_z ? step_coord(pos_q.z, neg_q[0]) : pos_q.z;
    e1_nxt = (e1_q[ERR_MSB] ? e1_q : e1_q - twice(d_q)) + twice(a1_q);
    e2_nxt = (e2_q[ERR_MSB] ? e2_q : e2_q - twice(d_q)) + twice(a2_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_q   <= '0;
      p2_q   <= '0;
      pos_q  <= '0;
      neg_q  <= '0;
      maj_q  <= AXIS_X;
      min1_q <= AXIS_Y;
      min2_q <= AXIS_Z;
      d_q    <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      cnt_q  <= '0;
      e1_q   <= '0;
      e2_q   <= '0;
      vld_q  <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        p1_q   <= point_1;
        p2_q   <= point_2;
        busy_q <= 1'b1;
      end
      // SETUP registers the setup results; the start point is presented from the next cycle.
      if (state_q == SETUP) begin
        maj_q  <= su_major;
        min1_q <= su_minor1;
        min2_q <= su_minor2;
        neg_q  <= su_neg;
        d_q    <= su_d;
        a1_q   <= su_a1;
        a2_q   <= su_a2;
        e1_q   <= su_e1;
        e2_q   <= su_e2;
        cnt_q  <= su_d;
        pos_q  <= p1_q;
      end
      if (state_q == RUN) begin
        if (!vld_q) begin
          vld_q <= 1'b1;
        end else if (advance) begin
          if (cnt_q == '0) begin
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
          end else begin
            pos_q <= pos_nxt;
            e1_q  <= e1_nxt;
            e2_q  <= e2_nxt;
            cnt_q <= cnt_q - COORD_W'(1);
          end
        end
      end
    end
  end

  assign ack_line    = ack_q;
  assign busy        = busy_q;
  assign point_valid = vld_q;
  assign point_out   = pos_q;
  assign eoc         = vld_q && (cnt_q == '0);

endmodule

// File: tb/tb_bresenham_line.sv
// Randomised bench for bresenham_line: expected points come from the closed-form
// rounded interpolation offset = floor((2*a*i + D) / (2*D)) per axis.
module tb_bresenham_line;

  logic        clk;
  logic        rst;
  logic        req_line;
  logic        ack_line;
  logic [23:0] point_1;
  logic [23:0] point_2;
  logic        step;
  logic [23:0] point_out;
  logic        point_valid;
  logic        eoc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bresenham_line dut (
    .clk         (clk),
    .rst         (rst),
    .req_line    (req_line),
    .ack_line    (ack_line),
    .point_1     (point_1),
    .point_2     (point_2),
    .step        (step),
    .point_out   (point_out),
    .point_valid (point_valid),
    .eoc         (eoc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [7:0] interp(input int s, input int e, input int i, input int d);
    int a;
    int off;
    a   = iabs(e - s);
    off = (d == 0) ? 0 : (2 * a * i + d) / (2 * d);
    return (e >= s) ? 8'(s + off) : 8'(s - off);
  endfunction

  // mode 0: step held high; mode 1: random step; mode 2: 3-cycle stall on the second point.
  task automatic run_line(input logic [23:0] p1, input logic [23:0] p2,
                          input int mode, input bit poke_req);
    logic [23:0] exp_q[$];
    int sx, sy, sz, ex, ey, ez, d, idx, stall, cyc;
    sx = int'(p1[23:16]); sy = int'(p1[15:8]); sz = int'(p1[7:0]);
    ex = int'(p2[23:16]); ey = int'(p2[15:8]); ez = int'(p2[7:0]);
    d = iabs(ex - sx);
    if (iabs(ey - sy) > d) d = iabs(ey - sy);
    if (iabs(ez - sz) > d) d = iabs(ez - sz);
    exp_q.delete();
    for (int i = 0; i <= d; i++)
      exp_q.push_back({interp(sx, ex, i, d), interp(sy, ey, i, d), interp(sz, ez, i, d)});

    point_1  = p1;
    point_2  = p2;
    req_line = 1'b1;
    step     = (mode == 0);
    @(negedge clk);
    check("ack_rise", ack_line, 1);
    check("busy_rise", busy, 1);
    check("valid_setup", point_valid, 0);
    req_line = 1'b0;
    @(negedge clk);
    check("ack_pulse", ack_line, 0);
    check("valid_n1", point_valid, 0);
    @(negedge clk);
    idx   = 0;
    stall = 0;
    cyc   = 0;
    while (idx <= d && cyc < 4000) begin
      check("valid", point_valid, 1);
      check("point", point_out, exp_q[idx]);
      check("eoc", eoc, (idx == d));
      check("busy_run", busy, 1);
      check("ack_run", ack_line, 0);
      if (mode == 1)
        step = 1'($urandom_range(0, 1));
      else if (mode == 2 && idx == 1 && stall < 3) begin
        step = 1'b0;
        stall++;
      end else
        step = 1'b1;
      req_line = (poke_req && idx < d) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (step) idx++;
      cyc++;
      @(negedge clk);
    end
    check("line_done", idx, d + 1);
    check("valid_drop", point_valid, 0);
    check("busy_drop", busy, 0);
    check("eoc_drop", eoc, 0);
    check("ack_idle", ack_line, 0);
    step     = 1'b0;
    req_line = 1'b0;
  endtask

  initial begin
    logic [23:0] r1;
    logic [23:0] r2;
    rst      = 1'b1;
    req_line = 1'b0;
    step     = 1'b0;
    point_1  = '0;
    point_2  = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_valid", point_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_point", point_out, 0);
    check("rst_eoc", eoc, 0);
    check("rst_ack", ack_line, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_line(24'h000000, 24'h000000, 0, 1'b0);
    run_line(24'h000000, 24'h040200, 0, 1'b0);
    run_line(24'h326432, 24'h2F6432, 0, 1'b0);
    run_line(24'h000000, 24'h000003, 2, 1'b0);
    run_line(24'h000000, 24'h050505, 0, 1'b1);
    run_line(24'h000000, 24'h030303, 0, 1'b0);
    run_line(24'hFF00FF, 24'h00FF00, 0, 1'b0);

    point_1  = 24'h000000;
    point_2  = 24'h0A0000;
    req_line = 1'b1;
    step     = 1'b1;
    @(negedge clk);
    req_line = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_valid", point_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", point_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_point", point_out, 0);
    check("mid_rst_eoc", eoc, 0);
    @(negedge clk);
    rst = 1'b1;
    run_line(24'h64C864, 24'h453265, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      r1 = 24'($urandom);
      r2 = ($urandom_range(0, 7) == 0) ? r1 : 24'($urandom);
      run_line(r1, r2, 1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
